keypad_emulator: RTL and testbench

//  Behavioural 4x4 keypad matrix model, i.e. the switch side of the row/col scan interface.
//  - Accepts key-press commands through a valid/ready handshake.
//  - Closes the addressed row/col contact with programmable mechanical chatter on press and release.
//  - Presents active-low col lines in response to the scanner's active-low row drive.
//  - Used in simulation and in on-FPGA loopback self-test of the keypad scanner + digit display path.

---
 rtl/keypad_emulator.sv | 225 ++++++++++++++++++++++
 tb/tb_keypad_emulator.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_emulator.sv
// Switch-side model of a 4x4 keypad matrix: a handshake command closes one row/col
// contact with LFSR-driven chatter on both edges, and the scanner sees it through col.
module keypad_emulator #(
  parameter int unsigned BOUNCE_CYCLES = 16,
  parameter int unsigned GAP_CYCLES    = 4,
  parameter int unsigned HOLD_W        = 24,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
  input  logic              clk,
  input  logic              resetInv,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_key,
  input  logic [HOLD_W-1:0] cmd_hold,
  input  logic [3:0]        row,
  output logic [3:0]        col,
  output logic              pressed,
  output logic              busy,
  output logic              done
);

  localparam int unsigned BNC_W = (BOUNCE_CYCLES > 1) ? $clog2(BOUNCE_CYCLES) : 1;
  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned BG_W  = (BNC_W > GAP_W) ? BNC_W : GAP_W;
  localparam int unsigned CNT_W = (HOLD_W > BG_W) ? HOLD_W : BG_W;

  localparam bit HAS_BNC = (BOUNCE_CYCLES != 0);
  localparam bit HAS_GAP = (GAP_CYCLES != 0);

  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
  localparam logic [CNT_W-1:0]  BNC_LAST = CNT_W'(HAS_BNC ? BOUNCE_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0]  GAP_LAST = CNT_W'(HAS_GAP ? GAP_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PRESS_BNC = 3'd1,
    S_HOLD      = 3'd2,
    S_REL_BNC   = 3'd3,
    S_GAP       = 3'd4
  } state_t;

  state_t            state_r, state_nxt;
  logic [CNT_W-1:0]  cnt_r, cnt_nxt;
  logic [HOLD_W-1:0] hold_r, hold_nxt;
  logic [1:0]        row_idx_r, row_idx_nxt;
  logic [1:0]        col_idx_r, col_idx_nxt;
  logic [7:0]        lfsr_r, lfsr_nxt;
  logic              contact_r, contact_nxt;
  logic              done_r, done_nxt;
  logic              ready_r, ready_nxt;
  logic [HOLD_W-1:0] hold_in_s;
  logic [CNT_W-1:0]  hold_in_last_s;
  logic [CNT_W-1:0]  hold_last_s;
  logic              last_s;

  // Fibonacci LFSR, taps 8,6,5,4, shifting left
  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // Returns {row, col} of a hex key on the keypad face
  function automatic logic [3:0] key_pos(input logic [3:0] key);
    logic [3:0] pos;
    case (key)
      4'h1:    pos = {2'd0, 2'd0};
      4'h2:    pos = {2'd0, 2'd1};
      4'h3:    pos = {2'd0, 2'd2};
      4'hA:    pos = {2'd0, 2'd3};
      4'h4:    pos = {2'd1, 2'd0};
      4'h5:    pos = {2'd1, 2'd1};
      4'h6:    pos = {2'd1, 2'd2};
      4'hB:    pos = {2'd1, 2'd3};
      4'h7:    pos = {2'd2, 2'd0};
      4'h8:    pos = {2'd2, 2'd1};
      4'h9:    pos = {2'd2, 2'd2};
      4'hC:    pos = {2'd2, 2'd3};
      4'hE:    pos = {2'd3, 2'd0};
      4'h0:    pos = {2'd3, 2'd1};
      4'hF:    pos = {2'd3, 2'd2};
      4'hD:    pos = {2'd3, 2'd3};
      default: pos = {2'd0, 2'd0};
    endcase
    return pos;
  endfunction

  // The last non-idle phase of a command is the one whose final cycle carries done
  function automatic logic is_final_phase(input state_t s);
    logic fin;
    case (s)
      S_GAP:     fin = 1'b1;
      S_REL_BNC: fin = !HAS_GAP;
      S_HOLD:    fin = !HAS_BNC && !HAS_GAP;
      default:   fin = 1'b0;
    endcase
    return fin;
  endfunction

  assign hold_in_s      = (cmd_hold == '0) ? HOLD_ONE : cmd_hold;
  assign hold_in_last_s = CNT_W'(hold_in_s - HOLD_ONE);
  assign hold_last_s    = CNT_W'(hold_r - HOLD_ONE);
  assign last_s         = (cnt_r == '0);

  // Next-state, down-counter reload and registered-output decode
  always_comb begin
    state_nxt   = state_r;
    cnt_nxt     = cnt_r;
    hold_nxt    = hold_r;
    row_idx_nxt = row_idx_r;
    col_idx_nxt = col_idx_r;
    lfsr_nxt    = lfsr_r;
    case (state_r)
      S_IDLE: begin
        if (cmd_valid) begin
          hold_nxt                   = hold_in_s;
          {row_idx_nxt, col_idx_nxt} = key_pos(cmd_key);
          if (HAS_BNC) begin
            state_nxt = S_PRESS_BNC;
            cnt_nxt   = BNC_LAST;
          end else begin
            state_nxt = S_HOLD;
            cnt_nxt   = hold_in_last_s;
          end
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_PRESS_BNC: begin
        lfsr_nxt = lfsr_step(lfsr_r);
        if (last_s) begin
          state_nxt = S_HOLD;
          cnt_nxt   = hold_last_s;
        end else begin
          cnt_nxt = cnt_r - CNT_ONE;
        end
      end
      S_HOLD: begin
        if (last_s) begin
          if (HAS_BNC) begin
            state_nxt = S_REL_BNC;
            cnt_nxt   = BNC_LAST;
          end else if (HAS_GAP) begin
            state_nxt = S_GAP;
            cnt_nxt   = GAP_LAST;
          end else begin
            state_nxt = S_IDLE;
          end
        end else begin
          cnt_nxt = cnt_r - CNT_ONE;
        end
      end
      S_REL_BNC: begin
        lfsr_nxt = lfsr_step(lfsr_r);
        if (last_s) begin
          if (HAS_GAP) begin
            state_nxt = S_GAP;
            cnt_nxt   = GAP_LAST;
          end else begin
            state_nxt = S_IDLE;
          end
        end else begin
          cnt_nxt = cnt_r - CNT_ONE;
        end
      end
      S_GAP: begin
        if (last_s) begin
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt_r - CNT_ONE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase

    // Outputs are decoded from next-cycle values so they come straight off flops
    contact_nxt = (state_nxt == S_HOLD) ||
                  (((state_nxt == S_PRESS_BNC) || (state_nxt == S_REL_BNC)) && lfsr_nxt[0]);
    done_nxt    = (state_nxt != S_IDLE) && (cnt_nxt == '0) && is_final_phase(state_nxt);
    ready_nxt   = (state_nxt == S_IDLE);
  end

  // State, counters, latched command and registered outputs
  always_ff @(posedge clk or negedge resetInv) begin
    if (!resetInv) begin
      state_r   <= S_IDLE;
      cnt_r     <= '0;
      hold_r    <= '0;
      row_idx_r <= 2'd0;
      col_idx_r <= 2'd0;
      lfsr_r    <= LFSR_SEED;
      contact_r <= 1'b0;
      done_r    <= 1'b0;
      ready_r   <= 1'b1;
    end else begin
      state_r   <= state_nxt;
      cnt_r     <= cnt_nxt;
      hold_r    <= hold_nxt;
      row_idx_r <= row_idx_nxt;
      col_idx_r <= col_idx_nxt;
      lfsr_r    <= lfsr_nxt;
      contact_r <= contact_nxt;
      done_r    <= done_nxt;
      ready_r   <= ready_nxt;
    end
  end

  // Passive switch: zero-latency path from the scanner's row drive to col
  always_comb begin
    col = 4'hF;
    if (contact_r && !row[row_idx_r]) begin
      col[col_idx_r] = 1'b0;
    end else begin
      col = 4'hF;
    end
  end

  assign cmd_ready = ready_r;
  assign busy      = ~ready_r;
  assign pressed   = contact_r;
  assign done      = done_r;

endmodule

// File: tb/tb_keypad_emulator.sv
// Self-checking bench for keypad_emulator: a clean-edge instance (a) and a default
// chattering instance (b) checked against a phase-list reference model.
module tb_keypad_emulator;

  logic        clk = 1'b0;
  logic        reset_inv = 1'b0;

  logic        valid_a = 1'b0, ready_a, pressed_a, busy_a, done_a;
  logic [3:0]  key_a = 4'h0, row_a = 4'hF, col_a;
  logic [23:0] hold_a = 24'd0;

  logic        valid_b = 1'b0, ready_b, pressed_b, busy_b, done_b;
  logic [3:0]  key_b = 4'h0, row_b = 4'hF, col_b;
  logic [23:0] hold_b = 24'd0;

  int vectors = 0;
  int errors  = 0;
  logic [7:0] lfsr_m = 8'hA5;

  logic [3:0] keymap [0:3][0:3] = '{'{4'h1, 4'h2, 4'h3, 4'hA},
                                    '{4'h4, 4'h5, 4'h6, 4'hB},
                                    '{4'h7, 4'h8, 4'h9, 4'hC},
                                    '{4'hE, 4'h0, 4'hF, 4'hD}};

  keypad_emulator #(.BOUNCE_CYCLES(0), .GAP_CYCLES(4), .HOLD_W(24), .LFSR_SEED(8'hA5)) dut_a (
    .clk(clk), .resetInv(reset_inv), .cmd_valid(valid_a), .cmd_ready(ready_a),
    .cmd_key(key_a), .cmd_hold(hold_a), .row(row_a), .col(col_a),
    .pressed(pressed_a), .busy(busy_a), .done(done_a));

  keypad_emulator dut_b (
    .clk(clk), .resetInv(reset_inv), .cmd_valid(valid_b), .cmd_ready(ready_b),
    .cmd_key(key_b), .cmd_hold(hold_b), .row(row_b), .col(col_b),
    .pressed(pressed_b), .busy(busy_b), .done(done_b));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // col seen by the scanner for a given key, row drive and contact state
  function automatic logic [3:0] model_col(input logic [3:0] key, input logic [3:0] rw,
                                           input logic contact);
    logic [3:0] c;
    c = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 4; k++)
        if (keymap[r][k] == key && contact && !rw[r]) c[k] = 1'b0;
    return c;
  endfunction

  // One full command on instance b with every cycle compared against the phase list
  task automatic run_b(input logic [3:0] key, input logic [23:0] hold);
    bit   exp_c[$];
    int   h, n, tp, tr;
    logic prev;
    h = (hold == 24'd0) ? 1 : int'(hold);
    for (int k = 0; k < 16; k++) begin exp_c.push_back(lfsr_m[0]); lfsr_m = lfsr_step(lfsr_m); end
    for (int k = 0; k < h; k++)  exp_c.push_back(1'b1);
    for (int k = 0; k < 16; k++) begin exp_c.push_back(lfsr_m[0]); lfsr_m = lfsr_step(lfsr_m); end
    for (int k = 0; k < 4; k++)  exp_c.push_back(1'b0);
    n = exp_c.size();
    @(negedge clk);
    chk("b_ready_idle", ready_b, 1);
    valid_b = 1'b1; key_b = key; hold_b = hold;
    @(posedge clk);
    prev = 1'b0; tp = 0; tr = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      valid_b = 1'($urandom); key_b = 4'($urandom);
      hold_b = 24'($urandom_range(0, 3)); row_b = 4'($urandom);
      #1;
      chk("b_pressed", pressed_b, exp_c[i]);
      chk("b_done", done_b, (i == n - 1));
      chk("b_busy", busy_b, 1);
      chk("b_col", col_b, model_col(key, row_b, exp_c[i]));
      if (i > 0 && pressed_b !== prev) begin
        if (i < 16) tp++;
        else if (i >= 17 + h && i < 32 + h) tr++;
      end
      prev = pressed_b;
    end
    @(negedge clk);
    valid_b = 1'b0;
    #1;
    chk("b_ready_after", ready_b, 1);
    chk("b_busy_after", busy_b, 0);
    chk("b_done_after", done_b, 0);
    chk("b_col_after", col_b, 4'hF);
    chk("b_chatter_press", (tp > 0), 1);
    chk("b_chatter_rel", (tr > 0), 1);
  endtask

  typedef struct {
    logic [3:0]  key;
    logic [23:0] hold;
    logic [3:0]  rw;
    logic [3:0]  exp1;
    logic [3:0]  exp2;
  } vec_t;

  initial begin
    vec_t tbl[$];
    int   cnt, n_done, n_ready;
    int   done_at[$];

    // Reset asserted with commands offered: nothing may start
    valid_a = 1'b1; valid_b = 1'b1; row_a = 4'h0; row_b = 4'h0; key_a = 4'h5; key_b = 4'h5;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk("rst_col_a", col_a, 4'hF);
      chk("rst_col_b", col_b, 4'hF);
      chk("rst_ready_a", ready_a, 1);
      chk("rst_ready_b", ready_b, 1);
      chk("rst_done_a", done_a, 0);
      chk("rst_done_b", done_b, 0);
      chk("rst_pressed_b", pressed_b, 0);
    end
    valid_a = 1'b0; valid_b = 1'b0;
    reset_inv = 1'b1;

    // Key map / row-to-col vectors on the clean-edge instance
    tbl.push_back('{4'h1, 24'd2, 4'b1110, 4'b1110, 4'b1110});
    tbl.push_back('{4'hA, 24'd0, 4'b1110, 4'b0111, 4'b1111});
    tbl.push_back('{4'h6, 24'd3, 4'b1101, 4'b1011, 4'b1011});
    tbl.push_back('{4'h6, 24'd3, 4'b1011, 4'b1111, 4'b1111});
    tbl.push_back('{4'hC, 24'd1, 4'b1011, 4'b0111, 4'b1111});
    tbl.push_back('{4'h7, 24'd2, 4'b0000, 4'b1110, 4'b1110});
    tbl.push_back('{4'hE, 24'd2, 4'b0111, 4'b1110, 4'b1110});
    tbl.push_back('{4'h0, 24'd2, 4'b0110, 4'b1101, 4'b1101});
    tbl.push_back('{4'hF, 24'd2, 4'b1111, 4'b1111, 4'b1111});
    tbl.push_back('{4'h9, 24'd2, 4'b1010, 4'b1011, 4'b1011});
    tbl.push_back('{4'h3, 24'd2, 4'b1111, 4'b1111, 4'b1111});
    tbl.push_back('{4'hB, 24'd5, 4'b0101, 4'b0111, 4'b0111});
    foreach (tbl[e]) begin
      int len;
      len = ((tbl[e].hold == 24'd0) ? 1 : int'(tbl[e].hold)) + 4;
      @(negedge clk);
      valid_a = 1'b1; key_a = tbl[e].key; hold_a = tbl[e].hold; row_a = tbl[e].rw;
      @(posedge clk);
      @(negedge clk);
      valid_a = 1'b0;
      #1 chk("tbl_col_c1", col_a, tbl[e].exp1);
      @(negedge clk);
      #1 chk("tbl_col_c2", col_a, tbl[e].exp2);
      repeat (len - 1) @(negedge clk);
      #1 chk("tbl_ready", ready_a, 1);
    end

    // Key 5, hold 100, walking row: contact only seen on row 1, done at cycle 104
    @(negedge clk);
    valid_a = 1'b1; key_a = 4'h5; hold_a = 24'd100; row_a = 4'hF;
    @(posedge clk);
    for (int i = 1; i <= 108; i++) begin
      @(negedge clk);
      valid_a = 1'b0;
      row_a = ~(4'b0001 << ((i - 1) % 4));
      #1;
      chk("k5_col", col_a, (i <= 100 && row_a == 4'b1101) ? 4'b1101 : 4'b1111);
      chk("k5_done", done_a, (i == 104));
    end

    // Key D, hold 1, all rows low: exactly one cycle of col=0111
    @(negedge clk);
    valid_a = 1'b1; key_a = 4'hD; hold_a = 24'd1; row_a = 4'b0000;
    @(posedge clk);
    cnt = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      valid_a = 1'b0;
      #1;
      if (col_a == 4'b0111) cnt++;
      chk("kd_done", done_a, (i == 5));
    end
    chk("kd_one_cycle", cnt, 1);

    // Randomized commands with chatter on the default instance
    run_b(4'h5, 24'd4);
    run_b(4'h2, 24'd0);
    for (int t = 0; t < 18; t++) begin
      int idle;
      idle = $urandom_range(0, 3);
      for (int k = 0; k < idle; k++) begin
        @(negedge clk); #1;
        chk("b_idle_ready", ready_b, 1);
        chk("b_idle_pressed", pressed_b, 0);
      end
      run_b(4'($urandom), 24'($urandom_range(0, 12)));
    end
    run_b(4'h8, 24'd300);

    // Back-to-back: key 0 then key F with cmd_valid held high
    @(negedge clk);
    valid_b = 1'b1; key_b = 4'h0; hold_b = 24'd5; row_b = 4'b0000;
    @(posedge clk);
    n_done = 0; n_ready = 0;
    for (int i = 1; i <= 86; i++) begin
      @(negedge clk);
      if (i == 2) key_b = 4'hF;
      if (i == 84) valid_b = 1'b0;
      #1;
      if (done_b === 1'b1) begin n_done++; done_at.push_back(i); end
      if (i <= 83 && ready_b === 1'b1) n_ready++;
      if (i == 18) chk("b2b_col_key0", col_b, 4'b1101);
      if (i == 60) chk("b2b_col_keyF", col_b, 4'b1011);
    end
    chk("b2b_done_count", n_done, 2);
    chk("b2b_first_done", (done_at.size() > 0) ? done_at[0] : -1, 41);
    chk("b2b_second_done", (done_at.size() > 1) ? done_at[1] : -1, 83);
    chk("b2b_idle_cycles", n_ready, 1);
    chk("b2b_ready_end", ready_b, 1);
    for (int k = 0; k < 64; k++) lfsr_m = lfsr_step(lfsr_m);

    // Asynchronous reset in the middle of HOLD drops the contact at once
    @(negedge clk);
    valid_b = 1'b1; key_b = 4'h5; hold_b = 24'd50; row_b = 4'b1101;
    @(posedge clk);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      valid_b = 1'b0;
    end
    #1 chk("mid_hold_col", col_b, 4'b1101);
    #1 reset_inv = 1'b0;
    #1;
    chk("async_rst_col", col_b, 4'hF);
    chk("async_rst_pressed", pressed_b, 0);
    chk("async_rst_ready", ready_b, 1);
    chk("async_rst_busy", busy_b, 0);
    @(negedge clk);
    chk("async_rst_done", done_b, 0);
    reset_inv = 1'b1;
    lfsr_m = 8'hA5;
    run_b(4'hA, 24'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
